// File: rtl/utopia1_phy_cell_tx_if.sv
// Handshake bundle between a local cell source, the PHY cell transmitter and
// the ATM-layer Utopia receive port that the transmitter drives.
interface utopia1_phy_cell_tx_if;
    logic [423:0] cell_in;
    logic         cell_valid;
    logic         cell_ready;
    logic [7:0]   rx_data;
    logic         rx_soc;
    logic         rx_clav;
    logic         rx_en;

    // slave: the transmitter itself; master: source plus ATM-layer side
    modport slave (
        input  cell_in, cell_valid, rx_en,
        output cell_ready, rx_data, rx_soc, rx_clav
    );

    modport master (
        output cell_in, cell_valid, rx_en,
        input  cell_ready, rx_data, rx_soc, rx_clav
    );
endinterface

// File: rtl/utopia1_phy_cell_tx.sv
// PHY-side Utopia Level 1 cell transmitter: buffers one 53-byte ATM cell and
// streams it byte-by-byte under clav/en/soc, optionally regenerating the HEC.
module utopia1_phy_cell_tx #(
    parameter bit GEN_HEC = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    utopia1_phy_cell_tx_if.slave bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     cells_sent
);
    localparam int NBYTES = 53;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load;

    logic [7:0] buf_q     [NBYTES];
    logic [7:0] buf_d     [NBYTES];
    logic [7:0] load_byte [NBYTES];
    logic [7:0] hec_val;

    // CRC-8, poly 0x07, MSB first, init 0x00, result XOR 0x55
    function automatic logic [7:0] calc_hec(input logic [31:0] hdr);
        logic [7:0] crc;
        crc = 8'h00;
        for (int i = 31; i >= 0; i--) begin
            if (crc[7] ^ hdr[i]) begin
                crc = {crc[6:0], 1'b0} ^ 8'h07;
            end else begin
                crc = {crc[6:0], 1'b0};
            end
        end
        return crc ^ 8'h55;
    endfunction

    assign hec_val = calc_hec(bus.cell_in[423:392]);

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_buf
            if (gi == 4) begin : g_hec
                assign load_byte[gi] = GEN_HEC ? hec_val : bus.cell_in[423-8*gi -: 8];
            end else begin : g_raw
                assign load_byte[gi] = bus.cell_in[423-8*gi -: 8];
            end

            assign buf_d[gi] = load ? load_byte[gi] : buf_q[gi];

            // Payload storage needs no reset: it is only read while in SEND
            always_ff @(posedge clk) begin
                buf_q[gi] <= buf_d[gi];
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cell_valid) begin
                    load    = 1'b1;
                    idx_d   = 6'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!bus.rx_en) begin
                    if (idx_q == 6'd52) begin
                        idx_d   = 6'd0;
                        cnt_d   = cnt_q + 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 6'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.cell_ready = (state_q == IDLE);
    assign bus.rx_clav    = (state_q == SEND);
    assign bus.rx_soc     = (state_q == SEND) && (idx_q == 6'd0);
    assign bus.rx_data    = (state_q == SEND) ? buf_q[idx_q] : 8'h00;
    assign busy           = (state_q == SEND);
    assign cells_sent     = cnt_q;
endmodule

// File: tb/tb_utopia1_phy_cell_tx.sv
// Bench for utopia1_phy_cell_tx: two instances (HEC regenerated / 4-bit
// counter with HEC passthrough) checked every cycle against a cell-level model.
module tb_utopia1_phy_cell_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [423:0] cell_in = '0;
    logic cell_valid = 1'b0;
    logic rx_en = 1'b1;

    always #5 clk = ~clk;

    utopia1_phy_cell_tx_if bus0 ();
    utopia1_phy_cell_tx_if bus1 ();
    logic        busy0, busy1;
    logic [15:0] sent0;
    logic [3:0]  sent1;

    assign bus0.cell_in = cell_in;  assign bus1.cell_in = cell_in;
    assign bus0.cell_valid = cell_valid;  assign bus1.cell_valid = cell_valid;
    assign bus0.rx_en = rx_en;  assign bus1.rx_en = rx_en;

    utopia1_phy_cell_tx #(.GEN_HEC(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus0), .busy(busy0), .cells_sent(sent0));
    utopia1_phy_cell_tx #(.GEN_HEC(1'b0), .CNT_W(4)) dut_nh (
        .clk(clk), .rst(rst), .bus(bus1), .busy(busy1), .cells_sent(sent1));

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (cell level) ----------------
    logic [7:0] m_cell [53];
    bit m_active = 1'b0;
    int m_pos = 0;
    int m_count = 0;
    int m_loads = 0;
    logic [7:0] cap0 [$];
    logic [7:0] cap1 [$];
    logic [7:0] last_data0, last_data1;
    logic last_clav0, last_clav1;

    // HEC as polynomial long division of header*x^8 by x^8+x^2+x+1
    function automatic logic [7:0] model_hec(input logic [31:0] h);
        logic [39:0] r;
        r = {h, 8'h00};
        for (int b = 39; b >= 8; b--) begin
            if (r[b]) r[b -: 9] = r[b -: 9] ^ 9'h107;
        end
        return r[7:0] ^ 8'h55;
    endfunction

    function automatic logic [7:0] exp_byte(input int k, input int p);
        if (k == 0 && p == 4) return model_hec({m_cell[0], m_cell[1], m_cell[2], m_cell[3]});
        return m_cell[p];
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            if (m_active) $display("cell aborted by reset at byte %0d", m_pos);
            m_active = 1'b0; m_pos = 0; m_count = 0;
            cap0.delete(); cap1.delete();
        end else if (m_active) begin
            if (!rx_en) begin
                if (last_clav0) cap0.push_back(last_data0);
                if (last_clav1) cap1.push_back(last_data1);
                m_pos++;
                if (m_pos == 53) begin
                    int bad;
                    bad = 0;
                    check("cell_len0", cap0.size(), 53);
                    check("cell_len1", cap1.size(), 53);
                    for (int i = 0; i < 53 && i < cap0.size(); i++)
                        if (cap0[i] !== exp_byte(0, i)) bad++;
                    for (int i = 0; i < 53 && i < cap1.size(); i++)
                        if (cap1[i] !== exp_byte(1, i)) bad++;
                    check("cell_bytes", bad, 0);
                    m_count++;
                    $display("cell %0d sent: hdr %02h%02h%02h%02h hec %02h, byte mismatches %0d",
                             m_count, m_cell[0], m_cell[1], m_cell[2], m_cell[3],
                             exp_byte(0, 4), bad);
                    m_active = 1'b0; m_pos = 0;
                    cap0.delete(); cap1.delete();
                end
            end
        end else if (cell_valid) begin
            for (int b = 0; b < 53; b++) m_cell[b] = cell_in[423-8*b -: 8];
            m_active = 1'b1; m_pos = 0; m_loads++;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        last_data0 = bus0.rx_data; last_clav0 = bus0.rx_clav;
        last_data1 = bus1.rx_data; last_clav1 = bus1.rx_clav;
        if (chk_en) begin
            check("ready0", bus0.cell_ready, !m_active);
            check("ready1", bus1.cell_ready, !m_active);
            check("clav0", bus0.rx_clav, m_active);
            check("clav1", bus1.rx_clav, m_active);
            check("busy0", busy0, m_active);
            check("busy1", busy1, m_active);
            check("soc0", bus0.rx_soc, m_active && m_pos == 0);
            check("soc1", bus1.rx_soc, m_active && m_pos == 0);
            check("data0", bus0.rx_data, m_active ? exp_byte(0, m_pos) : 8'h00);
            check("data1", bus1.rx_data, m_active ? exp_byte(1, m_pos) : 8'h00);
            check("sent0", sent0, m_count % 65536);
            check("sent1", sent1, m_count % 16);
        end
    end

    // ---------------- rx_en driver ----------------
    int en_mode = 0;
    int s0 = 0, s20 = 0;
    initial forever begin
        @(negedge clk);
        case (en_mode)
            0: rx_en = 1'b0;
            1: rx_en = ($urandom_range(0, 2) == 0);
            default: begin
                if (m_active && m_pos == 0 && s0 < 3) begin rx_en = 1'b1; s0++; end
                else if (m_active && m_pos == 20 && s20 < 5) begin rx_en = 1'b1; s20++; end
                else rx_en = 1'b0;
            end
        endcase
    end

    // ---------------- stimulus ----------------
    function automatic logic [423:0] rand_cell();
        logic [423:0] c;
        for (int b = 0; b < 53; b++) c[423-8*b -: 8] = 8'($urandom_range(0, 255));
        return c;
    endfunction

    task automatic load_cell(input logic [423:0] c);
        int n;
        n = m_loads;
        cell_in = c;
        cell_valid = 1'b1;
        for (int i = 0; i < 300 && m_loads == n; i++) @(negedge clk);
        if (m_loads == n) check("load_timeout", 0, 1);
        cell_valid = 1'b0;
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 300 && !(m_active && m_pos == p); i++) @(negedge clk);
        if (!(m_active && m_pos == p)) check("pos_timeout", m_pos, p);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600 && m_active; i++) @(negedge clk);
        if (m_active) check("idle_timeout", 1, 0);
    endtask

    initial begin
        logic [423:0] c;
        int n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_ready", bus0.cell_ready, 1);
        check("rst_clav", bus0.rx_clav, 0);
        check("rst_data", bus0.rx_data, 0);
        check("rst_sent", sent0, 0);
        rst = 1'b0;
        @(negedge clk);

        // known cell: header 00 00 00 01, payload 00..2F
        en_mode = 0;
        c = '0;
        c[423:392] = 32'h0000_0001;
        c[391:384] = 8'hFF;
        for (int b = 5; b < 53; b++) c[423-8*b -: 8] = 8'(b - 5);
        load_cell(c);
        check("c1_soc", bus0.rx_soc, 1);
        check("c1_b0", bus0.rx_data, 8'h00);
        wait_pos(4);
        check("c1_hec_gen", bus0.rx_data, 8'h52);
        check("c1_hec_raw", bus1.rx_data, 8'hFF);
        wait_pos(52);
        check("c1_last", bus0.rx_data, 8'h2F);
        wait_idle();
        check("c1_clav_low", bus0.rx_clav, 0);
        check("c1_sent", sent0, 1);

        // zero header with HEC byte AA
        c = rand_cell();
        c[423:392] = 32'h0;
        c[391:384] = 8'hAA;
        load_cell(c);
        wait_pos(4);
        check("c2_hec_gen", bus0.rx_data, 8'h55);
        check("c2_hec_raw", bus1.rx_data, 8'hAA);
        wait_idle();

        // scripted stalls at bytes 0 and 20
        en_mode = 2; s0 = 0; s20 = 0;
        load_cell(rand_cell());
        wait_idle();
        en_mode = 0;

        // back-to-back A then B with cell_valid held
        n = m_loads;
        cell_in = rand_cell();
        cell_valid = 1'b1;
        for (int i = 0; i < 10 && m_loads == n; i++) @(negedge clk);
        cell_in = rand_cell();
        n = m_count;
        for (int i = 0; i < 100 && m_count == n; i++) @(negedge clk);
        check("b2b_gap_clav", bus0.rx_clav, 0);
        check("b2b_gap_ready", bus0.cell_ready, 1);
        @(negedge clk);
        check("b2b_load_clav", bus0.rx_clav, 1);
        check("b2b_load_soc", bus0.rx_soc, 1);
        cell_valid = 1'b0;
        wait_idle();
        check("b2b_sent", sent0, 5);

        // reset after byte 30 transferred
        load_cell(rand_cell());
        wait_pos(31);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_clav", bus0.rx_clav, 0);
        check("rst_mid_ready", bus0.cell_ready, 1);
        check("rst_mid_sent", sent0, 0);
        load_cell(rand_cell());
        check("post_rst_soc", bus0.rx_soc, 1);
        wait_idle();
        check("post_rst_sent", sent0, 1);

        // random traffic; 4-bit counter instance wraps at 16
        en_mode = 1;
        for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            load_cell(rand_cell());
            wait_idle();
            if (m_count == 16) check("wrap16", sent1, 0);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/utopia1_phy_cell_tx.md
# utopia1_phy_cell_tx

PHY-side Utopia Level 1 cell transmitter. It accepts whole 53-byte ATM cells from a local cell source and streams them byte-by-byte into an ATM-layer Utopia receive port of the switch, using the `clav`/`en`/`soc` handshake. It optionally regenerates the header HEC before transmission. It serves as the far-end driver for switch Rx ports, both in PHY models and in loopback paths.

## Interface
- `GEN_HEC`, default 1: when 1, byte 4 (HEC) is replaced at load by CRC-8 of bytes 0–3; when 0, the cell is sent unmodified.
- `CNT_W`, default 16: width of the sent-cell counter.

- `clk`  in  1  single clock. Ports are named as in the codebase; one clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `cell_in`  in  424  cell to send. Byte 0 is `[423:416]`, byte 52 is `[7:0]`, matching the packed layout of `ATMCellType`.
- `cell_valid`  in  1  `cell_in` is valid.
- `cell_ready`  out  1  block can accept a cell.
- `rx_data`  out  8  Utopia byte toward the ATM layer.
- `rx_soc`  out  1  start of cell; high while byte 0 is presented.
- `rx_clav`  out  1  cell available.
- `rx_en`  in  1  active-low read enable from the ATM layer.
- `busy`  out  1  a cell is loaded or in transfer.
- `cells_sent`  out  `CNT_W`  count of completely transferred cells.

## Operation
- Single 53-byte cell buffer, 6-bit byte index `idx` (0..52).
- States: IDLE, SEND.
  - IDLE: `cell_ready`=1, `rx_clav`=0.
  - In IDLE, when `cell_valid`=1 at an edge: capture the cell into the buffer, set `idx`=0, and go to SEND.
  - SEND: `cell_ready`=0, `rx_clav`=1, `busy`=1.
  - In SEND, a byte transfers at every edge where `rx_en`=0. At that edge `idx` increments.
  - In SEND, when `rx_en`=1 the transfer stalls: `idx`, `rx_data` and `rx_soc` hold.
  - The edge that transfers byte 52 (`idx`=52 and `rx_en`=0) returns the state to IDLE and increments `cells_sent`.
- Outputs in SEND:
  - `rx_data` = buffer byte `idx`.
  - `rx_soc` = (`idx`==0).
- Outputs in IDLE: `rx_data`=8'h00 and `rx_soc`=0.
- HEC generation (`GEN_HEC`=1):
  - Computed combinationally from `cell_in` bytes 0–3 at load.
  - Algorithm: CRC-8 with polynomial x^8+x^2+x+1 (0x07), MSB-first, init 0x00, final XOR 0x55. This is identical to the switch's `hec()` function.
  - The result is stored as buffer byte 4. All other bytes are stored verbatim.
- `cells_sent` wraps from all-ones to 0. It is not saturating.
- `cell_valid` while `cell_ready`=0 is ignored. The source must hold the cell until it sees `cell_ready`.
- `rx_en`=0 while in IDLE has no effect, and no data is consumed.

## Timing
- Reset values: `cell_ready`=1, `rx_clav`=0, `rx_soc`=0, `rx_data`=8'h00, `busy`=0, `cells_sent`=0, state IDLE, `idx`=0.
- Reset mid-cell aborts the transfer. The partial cell is discarded, is not counted, and is not resent.
- Load at edge N. From cycle N+1: `rx_clav`=1, `rx_soc`=1, `rx_data`=byte 0.
- With `rx_en` held low from cycle N+1, bytes 0..52 transfer on edges N+1..N+53.
- After edge N+53: `rx_clav`=0, `cell_ready`=1, and `cells_sent` shows +1.
- Back-to-back cells: a new cell can load at edge N+54 at the earliest. There is always at least one cycle with `rx_clav`=0 between cells.
- `rx_soc` is high for exactly the cycles while byte 0 is presented. With `rx_en` high at cell start, it stays high across the stall.
- `rst` has priority over every other event at the same edge, including a load or a final-byte transfer.

## Test plan
- Single cell, `GEN_HEC`=1, header 00 00 00 01, payload bytes 0x00..0x2F, `rx_en` low continuously:
  - Presented bytes 00 00 00 01 52 00 01 … 2F, with `rx_soc` on byte 0 only.
  - `rx_clav` falls after 53 transfers, and `cells_sent`=1.
- Header 00 00 00 00 with HEC byte 0xAA, `GEN_HEC`=1: byte 4 is sent as 0x55. With `GEN_HEC`=0: byte 4 is sent as 0xAA.
- Stalls: `rx_en` high for 3 cycles at byte 0 and for 5 cycles at byte 20:
  - `rx_data` and `rx_soc` hold during each stall.
  - Exactly 53 bytes transfer, and their order is unchanged.
- Back-to-back: `cell_valid` held high with cell A, then cell B:
  - B loads one cycle after A's last byte.
  - One `rx_clav`=0 cycle separates the two cells.
  - `cells_sent`=2.
- Reset asserted after byte 30 of a cell:
  - Next cycle: `rx_clav`=0, `cell_ready`=1, `cells_sent`=0.
  - A following cell sends a full 53 bytes starting with `rx_soc`.
- Counter wrap: preload (or send) 65535 cells, then one more → `cells_sent`=0.
